// File: rtl/channel_emu_pkg.sv
// Shared widths, types and fixed-point helpers for the pole-residue channel emulator.
package channel_emu_pkg;

  localparam int DW     = 16;
  localparam int CW     = 18;
  localparam int SW     = 24;
  localparam int NPOLE  = 26;
  localparam int MAXDLY = 64;

  localparam int AW   = $clog2(NPOLE);
  localparam int DLYW = $clog2(MAXDLY + 1);
  localparam int PTRW = $clog2(MAXDLY);
  localparam int ACCW = SW + $clog2(NPOLE);
  localparam int PSW  = SW + CW + 1;
  localparam int RPW  = PSW - CW + 1;
  localparam int RXW  = CW + DW + 1;
  localparam int RRW  = RXW - CW + 1;
  localparam int SUMW = RPW + 1;

  localparam logic [PSW-1:0] PS_HALF = PSW'(1'b1) << (CW - 2);
  localparam logic [RXW-1:0] RX_HALF = RXW'(1'b1) << (CW - 2);

  typedef struct packed {
    logic signed [CW-1:0] re;
    logic signed [CW-1:0] im;
  } cplx_coef_t;

  typedef struct packed {
    logic signed [SW-1:0] re;
    logic signed [SW-1:0] im;
  } cplx_state_t;

  typedef struct packed {
    cplx_coef_t pole;
    cplx_coef_t res;
  } coef_entry_t;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, EMIT = 2'd2} fsm_e;

  function automatic logic signed [RPW-1:0] rnd_ps(input logic signed [PSW-1:0] v);
    logic [PSW-1:0] t;
    t = v + PS_HALF;
    return t[PSW-1:CW-1];
  endfunction

  function automatic logic signed [RRW-1:0] rnd_rx(input logic signed [RXW-1:0] v);
    logic [RXW-1:0] t;
    t = v + RX_HALF;
    return t[RXW-1:CW-1];
  endfunction

  function automatic logic ovf_sw(input logic signed [SUMW-1:0] v);
    return !((&v[SUMW-1:SW-1]) || !(|v[SUMW-1:SW-1]));
  endfunction

  function automatic logic signed [SW-1:0] sat_sw(input logic signed [SUMW-1:0] v);
    if (ovf_sw(v)) return v[SUMW-1] ? {1'b1, {(SW-1){1'b0}}} : {1'b0, {(SW-1){1'b1}}};
    else return v[SW-1:0];
  endfunction

  function automatic logic ovf_dw(input logic signed [ACCW-1:0] v);
    return !((&v[ACCW-1:DW-1]) || !(|v[ACCW-1:DW-1]));
  endfunction

  function automatic logic signed [DW-1:0] sat_dw(input logic signed [ACCW-1:0] v);
    if (ovf_dw(v)) return v[ACCW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    else return v[DW-1:0];
  endfunction

endpackage

// File: rtl/channel_emu_pfe_mac.sv
// Combinational complex MAC for one pole: s_out = sat(rnd(p*s) + rnd(r*x)).
module cplx_mac
  import channel_emu_pkg::*;
(
  input  cplx_coef_t           pole,
  input  cplx_coef_t           res,
  input  cplx_state_t          s,
  input  logic signed [DW-1:0] x,
  output cplx_state_t          s_out,
  output logic                 sat
);

  logic signed [PSW-1:0]  ps_re_s, ps_im_s;
  logic signed [RXW-1:0]  rx_re_s, rx_im_s;
  logic signed [SUMW-1:0] sum_re_s, sum_im_s;

  assign ps_re_s = PSW'($signed(pole.re)) * PSW'($signed(s.re)) - PSW'($signed(pole.im)) * PSW'($signed(s.im));
  assign ps_im_s = PSW'($signed(pole.re)) * PSW'($signed(s.im)) + PSW'($signed(pole.im)) * PSW'($signed(s.re));
  assign rx_re_s = RXW'($signed(res.re)) * RXW'(x);
  assign rx_im_s = RXW'($signed(res.im)) * RXW'(x);

  assign sum_re_s = SUMW'(rnd_ps(ps_re_s)) + SUMW'(rnd_rx(rx_re_s));
  assign sum_im_s = SUMW'(rnd_ps(ps_im_s)) + SUMW'(rnd_rx(rx_im_s));

  assign s_out.re = sat_sw(sum_re_s);
  assign s_out.im = sat_sw(sum_im_s);
  assign sat      = ovf_sw(sum_re_s) | ovf_sw(sum_im_s);

endmodule

// File: rtl/channel_emu_pfe.sv
// Pole-residue IIR bank channel emulator with shadow/active coefficients and bulk delay.
module channel_emu_pfe
  import channel_emu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [DW-1:0]   out_data,
  output logic            out_valid,
  input  logic            out_ready,
  input  logic            cfg_we,
  input  logic [AW-1:0]   cfg_addr,
  input  logic [CW-1:0]   cfg_pole_re,
  input  logic [CW-1:0]   cfg_pole_im,
  input  logic [CW-1:0]   cfg_res_re,
  input  logic [CW-1:0]   cfg_res_im,
  input  logic [DLYW-1:0] cfg_dly,
  input  logic            cfg_commit,
  input  logic            cfg_clear,
  output logic            sat_flag
);

  fsm_e                  state_r, state_next_s;
  logic [AW-1:0]         k_r;
  logic signed [DW-1:0]  x_r;
  logic signed [ACCW-1:0] acc_r;
  coef_entry_t           shadow_r [NPOLE];
  coef_entry_t           active_r [NPOLE];
  cplx_state_t           st_r [NPOLE];
  logic [DLYW-1:0]       shadow_dly_r, dly_r, cfg_dly_clamped_s;
  logic                  commit_pend_r, clear_pend_r;
  logic [PTRW-1:0]       wr_ptr_r, rd_ptr_s;
  logic [MAXDLY-1:0]     dvalid_r;
  logic signed [DW-1:0]  ram_r [MAXDLY];
  logic                  apply_s, accept_s, do_clear_s, do_commit_s;
  coef_entry_t           cur_coef_s;
  cplx_state_t           mac_out_s;
  logic                  mac_sat_s;
  logic signed [DW-1:0]  y_s, delayed_s;
  logic                  y_ovf_s;

  // Pending config operations only land between samples, with no output outstanding.
  assign in_ready    = (state_r == IDLE) && !out_valid && !commit_pend_r && !clear_pend_r;
  assign apply_s     = (state_r == IDLE) && !out_valid && (commit_pend_r || clear_pend_r);
  assign accept_s    = in_valid && in_ready;
  assign do_clear_s  = apply_s && clear_pend_r;
  assign do_commit_s = apply_s && commit_pend_r;
  assign cfg_dly_clamped_s = (cfg_dly > DLYW'(MAXDLY)) ? DLYW'(MAXDLY) : cfg_dly;

  assign cur_coef_s = active_r[k_r];
  assign y_s        = sat_dw(acc_r);
  assign y_ovf_s    = ovf_dw(acc_r);
  assign rd_ptr_s   = wr_ptr_r - dly_r[PTRW-1:0];
  assign delayed_s  = dvalid_r[rd_ptr_s] ? ram_r[rd_ptr_s] : {DW{1'b0}};

  cplx_mac u_mac (
    .pole  (cur_coef_s.pole),
    .res   (cur_coef_s.res),
    .s     (st_r[k_r]),
    .x     (x_r),
    .s_out (mac_out_s),
    .sat   (mac_sat_s)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_next_s;
  end

  // FSM next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    if (accept_s) state_next_s = CALC; else state_next_s = IDLE;
      CALC:    if (k_r == AW'(NPOLE - 1)) state_next_s = EMIT; else state_next_s = CALC;
      EMIT:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Coefficient banks, delay setting and pending config flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NPOLE; i++) begin
        shadow_r[i] <= '0;
        active_r[i] <= '0;
      end
      shadow_dly_r  <= '0;
      dly_r         <= '0;
      commit_pend_r <= 1'b0;
      clear_pend_r  <= 1'b0;
    end else begin
      if (cfg_we && (cfg_addr < AW'(NPOLE)))
        shadow_r[cfg_addr] <= '{pole: '{re: cfg_pole_re, im: cfg_pole_im},
                                res:  '{re: cfg_res_re,  im: cfg_res_im}};
      if (cfg_commit) shadow_dly_r <= cfg_dly_clamped_s;
      if (do_commit_s) begin
        for (int i = 0; i < NPOLE; i++) active_r[i] <= shadow_r[i];
        dly_r <= shadow_dly_r;
      end
      commit_pend_r <= cfg_commit | (commit_pend_r & ~do_commit_s);
      clear_pend_r  <= cfg_clear  | (clear_pend_r  & ~do_clear_s);
    end
  end

  // Pole states, accumulator, pole index and sticky saturation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NPOLE; i++) st_r[i] <= '0;
      k_r      <= '0;
      x_r      <= '0;
      acc_r    <= '0;
      sat_flag <= 1'b0;
    end else if (do_clear_s) begin
      for (int i = 0; i < NPOLE; i++) st_r[i] <= '0;
      sat_flag <= 1'b0;
    end else begin
      case (state_r)
        IDLE: if (accept_s) begin
          x_r   <= $signed(in_data);
          acc_r <= '0;
          k_r   <= '0;
        end
        CALC: begin
          st_r[k_r] <= mac_out_s;
          acc_r     <= acc_r + ACCW'($signed(mac_out_s.re));
          k_r       <= k_r + AW'(1);
          if (mac_sat_s) sat_flag <= 1'b1;
        end
        EMIT: if (y_ovf_s) sat_flag <= 1'b1;
        default: ;
      endcase
    end
  end

  // Output register, delay write pointer and written-since-clear marks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      wr_ptr_r  <= '0;
      dvalid_r  <= '0;
    end else begin
      if (do_clear_s) dvalid_r <= '0;
      if (state_r == EMIT) begin
        out_data           <= (dly_r == DLYW'(0)) ? y_s : delayed_s;
        out_valid          <= 1'b1;
        dvalid_r[wr_ptr_r] <= 1'b1;
        wr_ptr_r           <= (wr_ptr_r == PTRW'(MAXDLY - 1)) ? PTRW'(0) : wr_ptr_r + PTRW'(1);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Delay line storage; an entry at dly==MAXDLY is read before being overwritten
  always_ff @(posedge clk) begin
    if (state_r == EMIT) ram_r[wr_ptr_r] <= y_s;
  end

endmodule

// File: tb/tb_channel_emu_pfe.sv
// Scoreboard bench for channel_emu_pfe against an integer-arithmetic reference model.
module tb_channel_emu_pfe;

  localparam int NP = 26;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid, in_ready;
  logic [15:0] out_data;
  logic        out_valid, out_ready;
  logic        cfg_we;
  logic [4:0]  cfg_addr;
  logic [17:0] cfg_pole_re, cfg_pole_im, cfg_res_re, cfg_res_im;
  logic [6:0]  cfg_dly;
  logic        cfg_commit, cfg_clear, sat_flag;

  always #5 clk = ~clk;

  channel_emu_pfe dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_pole_re(cfg_pole_re), .cfg_pole_im(cfg_pole_im),
    .cfg_res_re(cfg_res_re), .cfg_res_im(cfg_res_im), .cfg_dly(cfg_dly),
    .cfg_commit(cfg_commit), .cfg_clear(cfg_clear), .sat_flag(sat_flag)
  );

  typedef struct { int d; bit sat; } exp_t;
  exp_t exp_q[$];
  int   checks = 0, passed = 0;
  bit   hold_low = 1'b0, bp_rand = 1'b0;

  // reference model: active/shadow coefficient sets, complex pole states, delay history
  longint a_pr[NP], a_pi[NP], a_rr[NP], a_ri[NP];
  longint s_pr[NP], s_pi[NP], s_rr[NP], s_ri[NP];
  longint st_re[NP], st_im[NP];
  int     m_dly;
  bit     m_sat;
  int     hist[$];

  task automatic check(input string name, input bit ok, input longint act, input longint req);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, req);
  endtask

  function automatic longint rnd17(input longint v);
    return (v + 65536) >>> 17;
  endfunction

  function automatic longint sat_to(input longint v, input int bits);
    longint hi, lo;
    hi = (longint'(1) <<< (bits - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) begin m_sat = 1'b1; return hi; end
    if (v < lo) begin m_sat = 1'b1; return lo; end
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NP; k++) begin
      a_pr[k] = 0; a_pi[k] = 0; a_rr[k] = 0; a_ri[k] = 0;
      s_pr[k] = 0; s_pi[k] = 0; s_rr[k] = 0; s_ri[k] = 0;
      st_re[k] = 0; st_im[k] = 0;
    end
    m_dly = 0; m_sat = 1'b0;
    hist.delete();
    exp_q.delete();
  endtask

  task automatic model_sample(input int x);
    longint acc, a, b;
    int y, o;
    acc = 0;
    for (int k = 0; k < NP; k++) begin
      a = rnd17(a_pr[k] * st_re[k] - a_pi[k] * st_im[k]) + rnd17(a_rr[k] * x);
      b = rnd17(a_pr[k] * st_im[k] + a_pi[k] * st_re[k]) + rnd17(a_ri[k] * x);
      st_re[k] = sat_to(a, 24);
      st_im[k] = sat_to(b, 24);
      acc += st_re[k];
    end
    y = int'(sat_to(acc, 16));
    hist.push_back(y);
    if (m_dly == 0) o = y;
    else if (hist.size() > m_dly) o = hist[hist.size() - 1 - m_dly];
    else o = 0;
    if (hist.size() > 70) void'(hist.pop_front());
    exp_q.push_back('{o, m_sat});
  endtask

  task automatic cfg_write(input int idx, input int pr, input int pi, input int rr, input int ri);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = idx[4:0];
    cfg_pole_re = pr[17:0]; cfg_pole_im = pi[17:0]; cfg_res_re = rr[17:0]; cfg_res_im = ri[17:0];
    @(posedge clk); #1 cfg_we = 1'b0;
    if (idx < NP) begin s_pr[idx] = pr; s_pi[idx] = pi; s_rr[idx] = rr; s_ri[idx] = ri; end
  endtask

  task automatic cfg_ctl(input bit clr, input bit com, input int d);
    @(negedge clk);
    cfg_clear = clr; cfg_commit = com; cfg_dly = d[6:0];
    @(posedge clk); #1 cfg_clear = 1'b0; cfg_commit = 1'b0;
    if (clr) begin
      for (int k = 0; k < NP; k++) begin st_re[k] = 0; st_im[k] = 0; end
      hist.delete(); m_sat = 1'b0;
    end
    if (com) begin
      for (int k = 0; k < NP; k++) begin
        a_pr[k] = s_pr[k]; a_pi[k] = s_pi[k]; a_rr[k] = s_rr[k]; a_ri[k] = s_ri[k];
      end
      m_dly = (d > 64) ? 64 : d;
    end
  endtask

  task automatic send(input int x);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 400) begin @(negedge clk); n++; end
    if (!in_ready) check("in_ready_timeout", 1'b0, 0, 1);
    else begin
      in_valid = 1'b1; in_data = x[15:0];
      @(posedge clk); #1 in_valid = 1'b0;
      model_sample(x);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin @(negedge clk); n++; end
    check("drain_timeout", exp_q.size() == 0, exp_q.size(), 0);
  endtask

  // out_ready pattern, changed just after each rising edge
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = hold_low ? 1'b0 : (bp_rand ? ($urandom_range(0, 2) != 0) : 1'b1);
    end
  end

  // Monitor: held data checked against queue head every cycle, popped on handshake
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (exp_q.size() == 0) check("unexpected_output", 1'b0, int'($signed(out_data)), 0);
        else begin
          check("out_data", int'($signed(out_data)) == exp_q[0].d, int'($signed(out_data)), exp_q[0].d);
          if (out_ready) begin
            check("sat_flag", sat_flag == exp_q[0].sat, sat_flag, exp_q[0].sat);
            check("in_ready_busy", in_ready == 1'b0, in_ready, 0);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; cfg_we = 1'b0; cfg_addr = '0;
    cfg_pole_re = '0; cfg_pole_im = '0; cfg_res_re = '0; cfg_res_im = '0;
    cfg_dly = '0; cfg_commit = 1'b0; cfg_clear = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid == 1'b0, out_valid, 0);
    check("rst_out_data", out_data == 16'd0, out_data, 0);
    check("rst_sat_flag", sat_flag == 1'b0, sat_flag, 0);
    check("rst_in_ready", in_ready == 1'b1, in_ready, 1);

    // single real pole, no delay
    cfg_write(0, 65536, 0, 65536, 0);
    cfg_ctl(1'b0, 1'b1, 0);
    send(16384); repeat (4) send(0);
    drain();

    // same pole, delay 3 after clear
    cfg_ctl(1'b1, 1'b1, 3);
    send(16384); repeat (4) send(0);
    drain();

    // imaginary pole
    cfg_write(0, 0, 65536, 65536, 0);
    cfg_ctl(1'b1, 1'b1, 0);
    send(16384); repeat (4) send(0);
    drain();

    // two slow poles driven by a full-scale step
    cfg_write(0, 129761, 0, 129761, 0);
    cfg_write(1, 129761, 0, 129761, 0);
    cfg_ctl(1'b1, 1'b1, 0);
    repeat (12) send(32767);
    drain();
    check("sat_sticky", sat_flag == m_sat, sat_flag, m_sat);

    // reset in the middle of a computation
    send(1000);
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", out_valid == 1'b0, out_valid, 0);
    check("midrst_in_ready", in_ready == 1'b1, in_ready, 1);
    check("midrst_sat_flag", sat_flag == 1'b0, sat_flag, 0);
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    send(1234);
    drain();

    // saturation cleared only by cfg_clear
    cfg_write(0, 129761, 0, 129761, 0);
    cfg_write(1, 129761, 0, 129761, 0);
    cfg_ctl(1'b0, 1'b1, 0);
    repeat (12) send(32767);
    drain();
    check("sat_set", sat_flag == m_sat, sat_flag, m_sat);
    cfg_ctl(1'b1, 1'b0, 0);
    repeat (3) @(negedge clk);
    check("sat_cleared", sat_flag == m_sat, sat_flag, m_sat);

    // backpressure: held output must stay equal to the queue head
    hold_low = 1'b1;
    send(-20000);
    repeat (40) @(negedge clk);
    check("bp_in_ready", in_ready == 1'b0, in_ready, 0);
    hold_low = 1'b0;
    drain();

    // commit during CALC, plus an out-of-range write that must be ignored
    cfg_write(0, 32768, 16384, -50000, 7000);
    cfg_write(29, 100000, 100000, 100000, 100000);
    send(9000);
    cfg_ctl(1'b0, 1'b1, 0);
    send(9000); send(-3000);
    drain();

    // randomized coefficient sets, delays (including clamp) and backpressure
    bp_rand = 1'b1;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < NP; k++)
        cfg_write(k, $urandom_range(0, 156000) - 78000, $urandom_range(0, 156000) - 78000,
                  (r < 2) ? $urandom_range(0, 16000) - 8000 : $urandom_range(0, 80000) - 40000,
                  $urandom_range(0, 16000) - 8000);
      cfg_ctl($urandom_range(0, 1), 1'b1, (r == 3) ? 100 : $urandom_range(0, 70));
      for (int i = 0; i < 30; i++) send($urandom_range(0, 65535) - 32768);
      if (r == 3) for (int i = 0; i < 70; i++) send($urandom_range(0, 65535) - 32768);
    end
    drain();
    bp_rand = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
